branch_resolver: RTL and testbench

Execute-stage consumer of the fetch-side branch predictor. It carries each fetched instruction's prediction (taken bit, predicted target, PC) alongside the F->D->E pipeline. In E it compares that prediction against the actual outcome and raises mispredict/redirect. One cycle later it emits a registered training-update packet back to the predictor and maintains saturating branch/mispredict counters.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_meta_stage.sv | 32 +++
 rtl/branch_resolver.sv | 139 +++++++++++++
 tb/tb_branch_resolver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch resolver.
//   pred_meta_t : prediction record carried alongside F->D->E
//   upd_t       : registered training packet sent back to the predictor
package bp_pkg;

  localparam int INDEX_BITS_DEF = 2;

  typedef struct packed {
    logic        valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pc;
  } pred_meta_t;

  // Holds PC[31:2]; index/tag are split out at the top level so the packet
  // layout does not depend on INDEX_BITS.
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic [29:0] line;
  } upd_t;

endpackage

// File: rtl/bp_meta_stage.sv
// bp_meta_stage: one pipeline register for a prediction record.
//   i_kill  : bubble the record (highest priority)
//   i_stall : hold current record
//   i_meta  : record to load when neither kill nor stall
//   o_meta  : registered record
module bp_meta_stage
  import bp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_kill,
  input  logic       i_stall,
  input  pred_meta_t i_meta,
  output pred_meta_t o_meta
);

  pred_meta_t meta_d, meta_q;

  always_comb begin
    meta_d = meta_q;
    if (i_kill)        meta_d = '0;
    else if (!i_stall) meta_d = i_meta;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) meta_q <= '0;
    else       meta_q <= meta_d;
  end

  assign o_meta = meta_q;

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: carries fetch-side predictions to E, checks them against
// the actual control-flow outcome, and requests a redirect on mismatch.
// A registered training packet follows each resolved conditional branch,
// and saturating counters track resolved control instructions/mispredicts.
//   i_PCF/i_predTakenF/i_predTargetF : fetch PC and its prediction
//   i_stallD/i_flushD/i_stallE/i_flushE : pipeline control for D/E records
//   i_branchE/i_JumpE/i_pc_selE/i_TargetE/i_PCPlus4E : actual E outcome
//   i_cntClear : synchronous counter clear
//   o_mispredict/o_redirectPC : combinational redirect
//   o_upd* : one-cycle training pulse, zero when not valid
//   o_branchCount/o_mispredCount : performance counters
module branch_resolver
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_PCF,
  input  logic                   i_predTakenF,
  input  logic [31:0]            i_predTargetF,
  input  logic                   i_stallD,
  input  logic                   i_flushD,
  input  logic                   i_stallE,
  input  logic                   i_flushE,
  input  logic                   i_branchE,
  input  logic                   i_JumpE,
  input  logic                   i_pc_selE,
  input  logic [31:0]            i_TargetE,
  input  logic [31:0]            i_PCPlus4E,
  input  logic                   i_cntClear,
  output logic                   o_mispredict,
  output logic [31:0]            o_redirectPC,
  output logic                   o_updValid,
  output logic [INDEX_BITS-1:0]  o_updIndex,
  output logic [29-INDEX_BITS:0] o_updTag,
  output logic                   o_updTaken,
  output logic [31:0]            o_updTarget,
  output logic [CNT_W-1:0]       o_branchCount,
  output logic [CNT_W-1:0]       o_mispredCount
);

  pred_meta_t meta_fch, meta_dec, meta_exe;
  logic       resolve, ctl, act_taken, mispredict;

  assign meta_fch = '{valid: 1'b1, pred_taken: i_predTakenF,
                      pred_target: i_predTargetF, pc: i_PCF};

  // A mispredict squashes both younger records even if they are stalled.
  bp_meta_stage u_stage_dec (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_kill  (mispredict | i_flushD),
    .i_stall (i_stallD),
    .i_meta  (meta_fch),
    .o_meta  (meta_dec)
  );

  bp_meta_stage u_stage_exe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_kill  (mispredict | i_flushE),
    .i_stall (i_stallE),
    .i_meta  (meta_dec),
    .o_meta  (meta_exe)
  );

  // Resolving only in the unstalled cycle makes each record count once.
  assign resolve   = meta_exe.valid & ~i_stallE;
  assign ctl       = i_branchE | i_JumpE;
  assign act_taken = i_JumpE | (i_branchE & i_pc_selE);

  // Non-control instructions look not-taken, so an aliased taken
  // prediction on them mispredicts back to the fall-through PC.
  assign mispredict = resolve &
                      ((act_taken != meta_exe.pred_taken) |
                       (act_taken & meta_exe.pred_taken &
                        (meta_exe.pred_target != i_TargetE)));

  assign o_mispredict = mispredict;
  assign o_redirectPC = mispredict ? (act_taken ? i_TargetE : i_PCPlus4E) : 32'h0;

  // Training packet: conditional branches only; jumps need no direction state.
  upd_t upd_d, upd_q;

  always_comb begin
    upd_d = '0;
    if (resolve && i_branchE) begin
      upd_d.valid  = 1'b1;
      upd_d.taken  = i_pc_selE;
      upd_d.target = i_TargetE;
      upd_d.line   = meta_exe.pc[31:2];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) upd_q <= '0;
    else       upd_q <= upd_d;
  end

  assign o_updValid  = upd_q.valid;
  assign o_updTaken  = upd_q.taken;
  assign o_updTarget = upd_q.target;
  assign o_updIndex  = upd_q.line[INDEX_BITS-1:0];
  assign o_updTag    = upd_q.line[29:INDEX_BITS];

  // Byte-offset bits of the PC take no part in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^meta_exe.pc[1:0];

  logic [CNT_W-1:0] br_cnt_d, br_cnt_q, mp_cnt_d, mp_cnt_q;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (i_cntClear) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else begin
      if (resolve && ctl && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mispredict && (mp_cnt_q != '1))     mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign o_branchCount  = br_cnt_q;
  assign o_mispredCount = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf, ptgtf, tgte, pcp4e;
  logic        ptf, stalld, flushd, stalle, flushe, bre, jmpe, sele, clr;
  logic        misp, updv, updt;
  logic [31:0] redir, updtgt;
  logic [1:0]  updidx;
  logic [27:0] updtag;
  logic [CNT_W-1:0] bc, mc;

  branch_resolver #(.INDEX_BITS(2), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_PCF(pcf), .i_predTakenF(ptf), .i_predTargetF(ptgtf),
    .i_stallD(stalld), .i_flushD(flushd), .i_stallE(stalle), .i_flushE(flushe),
    .i_branchE(bre), .i_JumpE(jmpe), .i_pc_selE(sele),
    .i_TargetE(tgte), .i_PCPlus4E(pcp4e), .i_cntClear(clr),
    .o_mispredict(misp), .o_redirectPC(redir),
    .o_updValid(updv), .o_updIndex(updidx), .o_updTag(updtag),
    .o_updTaken(updt), .o_updTarget(updtgt),
    .o_branchCount(bc), .o_mispredCount(mc)
  );

  always #5 clk = ~clk;

  logic [63:0] upd_got;
  assign upd_got = {updv, updidx, updtag, updt, updtgt};

  logic [63:0]      exp_q[$];
  logic [63:0]      u;
  logic [CNT_W-1:0] exp_bc, exp_mc;
  int               nchk = 0;
  int               nerr = 0;

  function automatic logic [63:0] mk_upd(input logic v, input logic [31:0] pc,
                                         input logic t, input logic [31:0] tg);
    return v ? {1'b1, pc[3:2], pc[31:4], t, tg} : 64'h0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_e();
    bre = 0; jmpe = 0; sele = 0; tgte = 0; pcp4e = 0;
  endtask

  // Feeds pc into F and one follow-on record (pc+4, predicted nxt_pt) so
  // that on return the pc record sits in E and the follow-on in D.
  task automatic issue(input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptg, input logic nxt_pt);
    clr_e();
    pcf = pc; ptf = pt; ptgtf = ptg;
    step();
    pcf = pc + 4; ptf = nxt_pt; ptgtf = 32'h500;
    step();
    pcf = 0; ptf = 0; ptgtf = 0;
  endtask

  task automatic test_reset();
    rst = 1; pcf = 0; ptf = 0; ptgtf = 0; stalld = 0; flushd = 0;
    stalle = 0; flushe = 0; clr = 0; clr_e();
    #12;
    nchk++; if ({misp, redir, updv, bc, mc} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got misp=%0d redir=%h updv=%0d bc=%0d mc=%0d, expected all 0", misp, redir, updv, bc, mc);
    end
    @(negedge clk); rst = 0;
    exp_bc = 0; exp_mc = 0;
    step();
  endtask

  task automatic test_mispredict_nt();
    issue(32'h40, 0, 0, 0);
    bre = 1; sele = 1; tgte = 32'h80; pcp4e = 32'h44;
    #1;
    nchk++; if (misp !== 1'b1 || redir !== 32'h80) begin
      nerr++; $display("FAIL nt_redirect: got misp=%0d redir=%h, expected 1 00000080", misp, redir);
    end
    exp_q.push_back(mk_upd(1, 32'h40, 1, 32'h80));
    exp_bc = sat_inc(exp_bc); exp_mc = sat_inc(exp_mc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || u !== {1'b1, 2'd0, 28'h4, 1'b1, 32'h80}) begin
      nerr++; $display("FAIL nt_update: got %h expected %h", upd_got, u);
    end
    nchk++; if (bc !== 1 || mc !== 1) begin
      nerr++; $display("FAIL nt_counts: got bc=%0d mc=%0d, expected 1 1", bc, mc);
    end
  endtask

  task automatic test_targets();
    // taken, wrong target
    issue(32'h58, 1, 32'h100, 0);
    bre = 1; sele = 1; tgte = 32'h120; pcp4e = 32'h5C;
    #1;
    nchk++; if (misp !== 1'b1 || redir !== 32'h120) begin
      nerr++; $display("FAIL wrong_target: got misp=%0d redir=%h, expected 1 00000120", misp, redir);
    end
    exp_q.push_back(mk_upd(1, 32'h58, 1, 32'h120));
    exp_bc = sat_inc(exp_bc); exp_mc = sat_inc(exp_mc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u) begin
      nerr++; $display("FAIL wrong_target_upd: got %h expected %h", upd_got, u);
    end
    // taken, right target
    issue(32'h5C, 1, 32'h100, 0);
    bre = 1; sele = 1; tgte = 32'h100; pcp4e = 32'h60;
    #1;
    nchk++; if (misp !== 1'b0 || redir !== 32'h0) begin
      nerr++; $display("FAIL correct_taken: got misp=%0d redir=%h, expected 0 00000000", misp, redir);
    end
    exp_q.push_back(mk_upd(1, 32'h5C, 1, 32'h100));
    exp_bc = sat_inc(exp_bc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u) begin
      nerr++; $display("FAIL correct_taken_upd: got %h expected %h", upd_got, u);
    end
    // not taken, predicted not taken
    issue(32'h60, 0, 0, 0);
    bre = 1; sele = 0; tgte = 32'h200; pcp4e = 32'h64;
    #1;
    nchk++; if (misp !== 1'b0) begin
      nerr++; $display("FAIL correct_nt: got misp=%0d, expected 0", misp);
    end
    exp_q.push_back(mk_upd(1, 32'h60, 0, 32'h200));
    exp_bc = sat_inc(exp_bc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || bc !== exp_bc || mc !== exp_mc) begin
      nerr++; $display("FAIL correct_nt_upd: got %h bc=%0d mc=%0d, expected %h bc=%0d mc=%0d", upd_got, bc, mc, u, exp_bc, exp_mc);
    end
  endtask

  task automatic test_alias_jump();
    issue(32'h44, 1, 32'h100, 0);
    pcp4e = 32'h48;
    #1;
    nchk++; if (misp !== 1'b1 || redir !== 32'h48) begin
      nerr++; $display("FAIL alias_redirect: got misp=%0d redir=%h, expected 1 00000048", misp, redir);
    end
    exp_q.push_back(mk_upd(0, 0, 0, 0));
    exp_mc = sat_inc(exp_mc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || bc !== exp_bc || mc !== exp_mc) begin
      nerr++; $display("FAIL alias_upd: got %h bc=%0d mc=%0d, expected %h bc=%0d mc=%0d", upd_got, bc, mc, u, exp_bc, exp_mc);
    end
    issue(32'h70, 0, 0, 0);
    jmpe = 1; tgte = 32'h300; pcp4e = 32'h74;
    #1;
    nchk++; if (misp !== 1'b1 || redir !== 32'h300) begin
      nerr++; $display("FAIL jump_redirect: got misp=%0d redir=%h, expected 1 00000300", misp, redir);
    end
    exp_q.push_back(mk_upd(0, 0, 0, 0));
    exp_bc = sat_inc(exp_bc); exp_mc = sat_inc(exp_mc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || bc !== exp_bc || mc !== exp_mc) begin
      nerr++; $display("FAIL jump_upd: got %h bc=%0d mc=%0d, expected %h bc=%0d mc=%0d", upd_got, bc, mc, u, exp_bc, exp_mc);
    end
  endtask

  task automatic test_stall();
    // follow-on record at 0x84 is wrong-path and predicted taken
    issue(32'h80, 0, 0, 1);
    stalld = 1; stalle = 1;
    bre = 1; sele = 1; tgte = 32'h400; pcp4e = 32'h84;
    for (int c = 0; c < 3; c++) begin
      #1;
      nchk++; if (misp !== 1'b0 || updv !== 1'b0) begin
        nerr++; $display("FAIL stall_hold%0d: got misp=%0d updv=%0d, expected 0 0", c, misp, updv);
      end
      step();
    end
    stalld = 0; stalle = 0;
    #1;
    nchk++; if (misp !== 1'b1 || redir !== 32'h400) begin
      nerr++; $display("FAIL stall_release: got misp=%0d redir=%h, expected 1 00000400", misp, redir);
    end
    exp_q.push_back(mk_upd(1, 32'h80, 1, 32'h400));
    exp_bc = sat_inc(exp_bc); exp_mc = sat_inc(exp_mc);
    step(); clr_e();
    u = exp_q.pop_front();
    #1;
    nchk++; if (upd_got !== u || bc !== exp_bc || mc !== exp_mc) begin
      nerr++; $display("FAIL stall_upd: got %h bc=%0d mc=%0d, expected %h bc=%0d mc=%0d", upd_got, bc, mc, u, exp_bc, exp_mc);
    end
    nchk++; if (misp !== 1'b0) begin
      nerr++; $display("FAIL stall_wrong_path_bubble: got misp=%0d, expected 0", misp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs = '{32'hA0, 32'hA4, 32'hA8, 32'hAC};
    clr_e();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        pcf = pcs[k]; ptf = k[0]; ptgtf = 32'h1000 + 32'(k) * 16;
      end else begin
        pcf = 0; ptf = 0; ptgtf = 0;
      end
      if (k >= 2) begin
        bre = 1; sele = k[0]; tgte = 32'h1000 + 32'(k - 2) * 16; pcp4e = pcs[k-2] + 4;
        #1;
        nchk++; if (misp !== 1'b0) begin
          nerr++; $display("FAIL b2b_misp%0d: got misp=%0d, expected 0", k, misp);
        end
        exp_q.push_back(mk_upd(1, pcs[k-2], k[0], tgte));
        exp_bc = sat_inc(exp_bc);
      end
      step();
      if (k >= 2) begin
        u = exp_q.pop_front();
        nchk++; if (upd_got !== u) begin
          nerr++; $display("FAIL b2b_upd%0d: got %h expected %h", k, upd_got, u);
        end
      end
    end
    clr_e();
    nchk++; if (bc !== exp_bc) begin
      nerr++; $display("FAIL b2b_count: got bc=%0d, expected %0d", bc, exp_bc);
    end
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 20; i++) begin
      issue(32'hF0, 0, 0, 0);
      bre = 1; sele = 1; tgte = 32'h700; pcp4e = 32'hF4;
      exp_bc = sat_inc(exp_bc); exp_mc = sat_inc(exp_mc);
      step();
    end
    clr_e();
    nchk++; if (bc !== exp_bc || mc !== exp_mc || bc !== 4'hF || mc !== 4'hF) begin
      nerr++; $display("FAIL saturate: got bc=%0d mc=%0d, expected %0d %0d", bc, mc, exp_bc, exp_mc);
    end
    issue(32'hE0, 0, 0, 0);
    bre = 1; sele = 1; tgte = 32'h600; pcp4e = 32'hE4; clr = 1;
    #1;
    nchk++; if (misp !== 1'b1) begin
      nerr++; $display("FAIL clear_misp: got misp=%0d, expected 1", misp);
    end
    exp_q.push_back(mk_upd(1, 32'hE0, 1, 32'h600));
    exp_bc = 0; exp_mc = 0;
    step(); clr_e(); clr = 0;
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || bc !== exp_bc || mc !== exp_mc) begin
      nerr++; $display("FAIL clear_wins: got %h bc=%0d mc=%0d, expected %h bc=0 mc=0", upd_got, bc, mc, u);
    end
  endtask

  task automatic test_reset_mid();
    // follow-on 0xC4 predicted taken stays valid in E behind a correct branch
    issue(32'hC0, 0, 0, 1);
    bre = 1; sele = 0; tgte = 32'h200; pcp4e = 32'hC4;
    exp_q.push_back(mk_upd(1, 32'hC0, 0, 32'h200));
    exp_bc = sat_inc(exp_bc);
    step(); clr_e(); pcp4e = 32'hC8;
    u = exp_q.pop_front();
    #1;
    nchk++; if (upd_got !== u || misp !== 1'b1 || bc !== exp_bc) begin
      nerr++; $display("FAIL pre_reset: got %h misp=%0d bc=%0d, expected %h 1 %0d", upd_got, misp, bc, u, exp_bc);
    end
    rst = 1;
    #1;
    nchk++; if ({misp, redir, upd_got, bc, mc} !== '0) begin
      nerr++; $display("FAIL reset_mid: got misp=%0d redir=%h upd=%h bc=%0d mc=%0d, expected all 0", misp, redir, upd_got, bc, mc);
    end
    exp_bc = 0; exp_mc = 0; exp_q.delete();
    pcf = 32'hD0; ptf = 0; ptgtf = 0;
    bre = 1; sele = 0; tgte = 32'h300; pcp4e = 32'hD4;
    #1; rst = 0;
    #1;
    nchk++; if (updv !== 1'b0) begin
      nerr++; $display("FAIL post_reset_r0: got updv=%0d, expected 0", updv);
    end
    step(); pcf = 0;
    nchk++; if (updv !== 1'b0 || misp !== 1'b0) begin
      nerr++; $display("FAIL post_reset_r1: got updv=%0d misp=%0d, expected 0 0", updv, misp);
    end
    step();
    nchk++; if (updv !== 1'b0 || misp !== 1'b0) begin
      nerr++; $display("FAIL post_reset_r2: got updv=%0d misp=%0d, expected 0 0", updv, misp);
    end
    exp_q.push_back(mk_upd(1, 32'hD0, 0, 32'h300));
    exp_bc = sat_inc(exp_bc);
    step(); clr_e();
    u = exp_q.pop_front();
    nchk++; if (upd_got !== u || bc !== exp_bc) begin
      nerr++; $display("FAIL post_reset_first: got %h bc=%0d, expected %h bc=%0d", upd_got, bc, u, exp_bc);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict_nt();
    test_targets();
    test_alias_jump();
    test_stall();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
